// File: rtl/header_buf_ingress_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : header_buf_ingress_arbiter_if
// Brief    : Ingress byte lanes plus header-buffer lanes and status for the
//            header buffer ingress arbiter.
// Revision : 1.0 - initial release
// ============================================================================
interface header_buf_ingress_arbiter_if #(
    parameter int NUM_PORTS = 4,
    parameter int PORT_W    = 2
);
    logic [NUM_PORTS-1:0]   in_valid;
    logic [8*NUM_PORTS-1:0] in_data;
    logic [NUM_PORTS-1:0]   in_last;
    logic [NUM_PORTS-1:0]   in_ready;
    logic                   buf_valid;
    logic [7:0]             buf_data;
    logic                   buf_last;
    logic                   buf_fire;
    logic                   buf_ready;
    logic [PORT_W-1:0]      hdr_src_port;
    logic                   trunc_pulse;
    logic [15:0]            drop_cnt;

    modport master (
        output in_valid, in_data, in_last, buf_ready,
        input  in_ready, buf_valid, buf_data, buf_last, buf_fire,
               hdr_src_port, trunc_pulse, drop_cnt
    );

    modport slave (
        input  in_valid, in_data, in_last, buf_ready,
        output in_ready, buf_valid, buf_data, buf_last, buf_fire,
               hdr_src_port, trunc_pulse, drop_cnt
    );
endinterface
`default_nettype wire

// File: rtl/header_buf_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : header_buf_ingress_arbiter
// Brief    : Packet-granular round-robin arbiter feeding the header buffer,
//            with source tagging and oversize-packet truncation.
// Revision : 1.0 - initial release
// ============================================================================
module header_buf_ingress_arbiter #(
    parameter int NUM_PORTS   = 4,
    parameter int PORT_W      = 2,
    parameter int MAX_PKT_LEN = 1518,
    parameter int LEN_W       = 11
) (
    input  logic                          clk,
    input  logic                          rst,
    header_buf_ingress_arbiter_if.slave   bus
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_XFER  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    localparam logic [LEN_W-1:0] C_LAST_IDX = LEN_W'(MAX_PKT_LEN - 1);
    localparam logic [15:0]      C_DROP_MAX = 16'hFFFF;

    state_t             r_state;
    state_t             w_next;
    logic [PORT_W-1:0]  r_grant;
    logic [PORT_W-1:0]  r_last_grant;
    logic [PORT_W-1:0]  r_hdr_src;
    logic [PORT_W-1:0]  w_pick;
    logic               w_any;
    int                 w_idx;
    logic [LEN_W-1:0]   r_byte_cnt;
    logic [15:0]        r_drop_cnt;
    logic               r_trunc;
    logic               w_sel_valid;
    logic               w_sel_last;
    logic               w_force_last;
    logic               w_xfer;
    logic               w_trunc;

    // Walk from farthest to nearest so the port right after last_grant wins.
    always_comb begin
        w_pick = '0;
        w_any  = 1'b0;
        w_idx  = 0;
        for (int i = NUM_PORTS; i >= 1; i--) begin
            w_idx = (int'(r_last_grant) + i) % NUM_PORTS;
            if (bus.in_valid[w_idx]) begin
                w_pick = PORT_W'(w_idx);
                w_any  = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next        = r_state;
        bus.buf_valid = 1'b0;
        bus.buf_fire  = 1'b0;
        bus.buf_data  = 8'h00;
        bus.buf_last  = 1'b0;
        bus.in_ready  = '0;
        w_xfer        = 1'b0;
        w_trunc       = 1'b0;
        w_sel_valid   = bus.in_valid[r_grant];
        w_sel_last    = bus.in_last[r_grant];
        w_force_last  = (r_byte_cnt == C_LAST_IDX);
        case (r_state)
            ST_IDLE: begin
                if (w_any) begin
                    w_next = ST_XFER;
                end
            end
            ST_XFER: begin
                bus.buf_valid         = w_sel_valid;
                bus.buf_fire          = w_sel_valid;
                bus.buf_data          = bus.in_data[{r_grant, 3'b000} +: 8];
                bus.buf_last          = w_sel_last | w_force_last;
                bus.in_ready[r_grant] = bus.buf_ready;
                w_xfer                = w_sel_valid & bus.buf_ready;
                // A real last on the length limit is a normal end, not a truncation.
                if (w_xfer) begin
                    if (w_sel_last) begin
                        w_next = ST_IDLE;
                    end else if (w_force_last) begin
                        w_next  = ST_DRAIN;
                        w_trunc = 1'b1;
                    end
                end
            end
            ST_DRAIN: begin
                bus.in_ready[r_grant] = 1'b1;
                if (w_sel_valid && w_sel_last) begin
                    w_next = ST_IDLE;
                end
            end
            default: begin
                w_next = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_grant      <= '0;
            r_last_grant <= PORT_W'(NUM_PORTS - 1);
            r_hdr_src    <= '0;
            r_byte_cnt   <= '0;
            r_drop_cnt   <= '0;
            r_trunc      <= 1'b0;
        end else begin
            r_trunc <= w_trunc;
            if ((r_state == ST_IDLE) && w_any) begin
                r_grant    <= w_pick;
                r_hdr_src  <= w_pick;
                r_byte_cnt <= '0;
            end
            if (w_xfer) begin
                r_byte_cnt <= r_byte_cnt + LEN_W'(1);
            end
            if ((r_state != ST_IDLE) && (w_next == ST_IDLE)) begin
                r_last_grant <= r_grant;
            end
            if (w_trunc && (r_drop_cnt != C_DROP_MAX)) begin
                r_drop_cnt <= r_drop_cnt + 16'd1;
            end
        end
    end

    assign bus.hdr_src_port = r_hdr_src;
    assign bus.trunc_pulse  = r_trunc;
    assign bus.drop_cnt     = r_drop_cnt;

endmodule
`default_nettype wire

// File: tb/tb_header_buf_ingress_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_header_buf_ingress_arbiter
// Brief    : Directed bench for the header buffer ingress arbiter; dut_a uses
//            the default length limit, dut_b a limit of 4 bytes.
// Revision : 1.0 - initial release
// ============================================================================
module tb_header_buf_ingress_arbiter;

    logic        clk;
    logic        rst;
    logic [3:0]  drv_valid;
    logic [31:0] drv_data;
    logic [3:0]  drv_last;
    logic        drv_ready;
    logic        use_b;

    logic [8:0]  mem [4][16];
    int          len [4];
    int          rd  [4];
    logic [3:0]  en;
    logic [63:0] rdy_pat;

    logic        obs_valid [64];
    logic        obs_fire  [64];
    logic [7:0]  obs_data  [64];
    logic        obs_last  [64];
    logic [3:0]  obs_rdy   [64];
    logic [1:0]  obs_src   [64];
    logic        obs_trunc [64];
    logic [15:0] obs_drop  [64];
    logic [7:0]  fired_data [64];
    logic        fired_last [64];
    int          ncyc;
    int          nfired;
    int          vec_cnt;
    int          err_cnt;

    header_buf_ingress_arbiter_if #(.NUM_PORTS(4), .PORT_W(2)) ifa ();
    header_buf_ingress_arbiter_if #(.NUM_PORTS(4), .PORT_W(2)) ifb ();

    assign ifa.in_valid  = use_b ? 4'b0000 : drv_valid;
    assign ifa.in_data   = drv_data;
    assign ifa.in_last   = use_b ? 4'b0000 : drv_last;
    assign ifa.buf_ready = drv_ready;
    assign ifb.in_valid  = use_b ? drv_valid : 4'b0000;
    assign ifb.in_data   = drv_data;
    assign ifb.in_last   = use_b ? drv_last : 4'b0000;
    assign ifb.buf_ready = drv_ready;

    header_buf_ingress_arbiter #(
        .NUM_PORTS(4), .PORT_W(2), .MAX_PKT_LEN(1518), .LEN_W(11)
    ) dut_a (
        .clk (clk),
        .rst (rst),
        .bus (ifa)
    );

    header_buf_ingress_arbiter #(
        .NUM_PORTS(4), .PORT_W(2), .MAX_PKT_LEN(4), .LEN_W(11)
    ) dut_b (
        .clk (clk),
        .rst (rst),
        .bus (ifb)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic drive();
        for (int p = 0; p < 4; p++) begin
            if (en[p] && (rd[p] < len[p])) begin
                drv_valid[p]       = 1'b1;
                drv_data[8*p +: 8] = mem[p][rd[p]][7:0];
                drv_last[p]        = mem[p][rd[p]][8];
            end else begin
                drv_valid[p]       = 1'b0;
                drv_data[8*p +: 8] = 8'h00;
                drv_last[p]        = 1'b0;
            end
        end
        drv_ready = rdy_pat[ncyc];
    endtask

    // One clock: present source heads, capture outputs mid-cycle, pop on the edge.
    task automatic tick();
        drive();
        @(negedge clk);
        if (use_b) begin
            obs_valid[ncyc] = ifb.buf_valid;    obs_fire[ncyc]  = ifb.buf_fire;
            obs_data[ncyc]  = ifb.buf_data;     obs_last[ncyc]  = ifb.buf_last;
            obs_rdy[ncyc]   = ifb.in_ready;     obs_src[ncyc]   = ifb.hdr_src_port;
            obs_trunc[ncyc] = ifb.trunc_pulse;  obs_drop[ncyc]  = ifb.drop_cnt;
        end else begin
            obs_valid[ncyc] = ifa.buf_valid;    obs_fire[ncyc]  = ifa.buf_fire;
            obs_data[ncyc]  = ifa.buf_data;     obs_last[ncyc]  = ifa.buf_last;
            obs_rdy[ncyc]   = ifa.in_ready;     obs_src[ncyc]   = ifa.hdr_src_port;
            obs_trunc[ncyc] = ifa.trunc_pulse;  obs_drop[ncyc]  = ifa.drop_cnt;
        end
        if (obs_valid[ncyc] && drv_ready) begin
            fired_data[nfired] = obs_data[ncyc];
            fired_last[nfired] = obs_last[ncyc];
            nfired++;
        end
        @(posedge clk);
        #1;
        for (int p = 0; p < 4; p++) begin
            if (obs_rdy[ncyc][p] && drv_valid[p]) rd[p]++;
        end
        ncyc++;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        drv_valid = 4'b0000;
        drv_last  = 4'b0000;
        drv_data  = 32'h0;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    task automatic begin_test(input logic b);
        use_b   = b;
        en      = 4'hF;
        rdy_pat = '1;
        ncyc    = 0;
        nfired  = 0;
        for (int p = 0; p < 4; p++) begin
            len[p] = 0;
            rd[p]  = 0;
        end
        do_reset();
    endtask

    task automatic load(input int p, input logic [7:0] first, input int cnt);
        for (int k = 0; k < cnt; k++) begin
            mem[p][len[p]] = {(k == cnt - 1), 8'(first + k)};
            len[p]++;
        end
    endtask

    task automatic test_reset();
        use_b = 1'b0;
        rst = 1'b1;
        drv_valid = 4'hF;
        drv_ready = 1'b1;
        #1;
        vec_cnt++; if (ifa.buf_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_buf_valid: got %b want 0", ifa.buf_valid); end
        vec_cnt++; if (ifa.in_ready !== 4'b0000) begin err_cnt++; $display("FAIL rst_in_ready: got %b want 0000", ifa.in_ready); end
        vec_cnt++; if (ifa.hdr_src_port !== 2'd0) begin err_cnt++; $display("FAIL rst_hdr_src: got %0d want 0", ifa.hdr_src_port); end
        vec_cnt++; if (ifa.drop_cnt !== 16'd0 || ifa.trunc_pulse !== 1'b0) begin err_cnt++; $display("FAIL rst_drop_trunc: got %0d/%b want 0/0", ifa.drop_cnt, ifa.trunc_pulse); end
        vec_cnt++; if (ifb.in_ready !== 4'b0000 || ifb.buf_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_dut_b: got %b/%b want 0000/0", ifb.in_ready, ifb.buf_valid); end
        // Ports 3 and 0 both request: initial last_grant of 3 makes port 0 win.
        begin_test(1'b0);
        load(3, 8'h33, 1);
        load(0, 8'h00, 1);
        tick(); tick();
        vec_cnt++; if (obs_rdy[0] !== 4'b0000) begin err_cnt++; $display("FAIL rst_idle_ready: got %b want 0000", obs_rdy[0]); end
        vec_cnt++; if (obs_src[1] !== 2'd0 || obs_rdy[1] !== 4'b0001) begin err_cnt++; $display("FAIL rst_first_winner: got src %0d rdy %b want 0/0001", obs_src[1], obs_rdy[1]); end
    endtask

    task automatic test_two_ports();
        begin_test(1'b0);
        load(0, 8'h10, 3);
        load(2, 8'h20, 3);
        for (int c = 0; c < 9; c++) tick();
        vec_cnt++; if (obs_valid[0] !== 1'b0) begin err_cnt++; $display("FAIL tp_arb_cycle: got valid %b want 0", obs_valid[0]); end
        vec_cnt++; if (obs_data[1] !== 8'h10 || obs_fire[1] !== 1'b1 || obs_rdy[1] !== 4'b0001) begin err_cnt++; $display("FAIL tp_p0_b0: got %h/%b/%b want 10/1/0001", obs_data[1], obs_fire[1], obs_rdy[1]); end
        vec_cnt++; if (obs_data[3] !== 8'h12 || obs_last[3] !== 1'b1 || obs_last[2] !== 1'b0) begin err_cnt++; $display("FAIL tp_p0_last: got %h/%b/%b want 12/1/0", obs_data[3], obs_last[3], obs_last[2]); end
        vec_cnt++; if (obs_valid[4] !== 1'b0 || obs_src[4] !== 2'd0) begin err_cnt++; $display("FAIL tp_gap: got valid %b src %0d want 0/0", obs_valid[4], obs_src[4]); end
        vec_cnt++; if (obs_data[5] !== 8'h20 || obs_src[5] !== 2'd2 || obs_rdy[5] !== 4'b0100) begin err_cnt++; $display("FAIL tp_p2_b0: got %h/%0d/%b want 20/2/0100", obs_data[5], obs_src[5], obs_rdy[5]); end
        vec_cnt++; if (obs_data[7] !== 8'h22 || obs_last[7] !== 1'b1) begin err_cnt++; $display("FAIL tp_p2_last: got %h/%b want 22/1", obs_data[7], obs_last[7]); end
        vec_cnt++; if (nfired !== 6) begin err_cnt++; $display("FAIL tp_count: got %0d want 6", nfired); end
    endtask

    task automatic test_round_robin();
        logic [7:0] exp_d [5];
        logic [3:0] exp_r [5];
        exp_d = '{8'h30, 8'h31, 8'h32, 8'h33, 8'h40};
        exp_r = '{4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0001};
        begin_test(1'b0);
        for (int p = 0; p < 4; p++) begin
            load(p, 8'(8'h30 + p), 1);
            load(p, 8'(8'h40 + p), 1);
        end
        for (int c = 0; c < 10; c++) tick();
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if (obs_data[2*k+1] !== exp_d[k] || obs_rdy[2*k+1] !== exp_r[k] || obs_last[2*k+1] !== 1'b1) begin
                err_cnt++; $display("FAIL rr_grant%0d: got %h/%b/%b want %h/%b/1", k, obs_data[2*k+1], obs_rdy[2*k+1], obs_last[2*k+1], exp_d[k], exp_r[k]);
            end
        end
        for (int c = 0; c < 10; c++) begin
            vec_cnt++;
            if (!$onehot0(obs_rdy[c])) begin err_cnt++; $display("FAIL rr_onehot c%0d: got %b want at most one bit", c, obs_rdy[c]); end
        end
    endtask

    task automatic test_stall();
        begin_test(1'b0);
        load(1, 8'h50, 5);
        rdy_pat = ~64'h6C;
        for (int c = 0; c < 11; c++) tick();
        vec_cnt++; if (obs_valid[2] !== 1'b1 || obs_data[2] !== 8'h51 || obs_rdy[2] !== 4'b0000) begin err_cnt++; $display("FAIL st_hold1: got %b/%h/%b want 1/51/0000", obs_valid[2], obs_data[2], obs_rdy[2]); end
        vec_cnt++; if (obs_data[3] !== 8'h51 || obs_data[4] !== 8'h51 || obs_rdy[4] !== 4'b0010) begin err_cnt++; $display("FAIL st_release1: got %h/%h/%b want 51/51/0010", obs_data[3], obs_data[4], obs_rdy[4]); end
        vec_cnt++; if (obs_data[6] !== 8'h52 || obs_rdy[6] !== 4'b0000 || obs_data[7] !== 8'h52) begin err_cnt++; $display("FAIL st_hold2: got %h/%b/%h want 52/0000/52", obs_data[6], obs_rdy[6], obs_data[7]); end
        vec_cnt++; if (obs_data[9] !== 8'h54 || obs_last[9] !== 1'b1 || obs_valid[10] !== 1'b0) begin err_cnt++; $display("FAIL st_end: got %h/%b/%b want 54/1/0", obs_data[9], obs_last[9], obs_valid[10]); end
        vec_cnt++; if (nfired !== 5) begin err_cnt++; $display("FAIL st_count: got %0d want 5", nfired); end
        for (int k = 0; k < 5; k++) begin
            vec_cnt++;
            if (fired_data[k] !== 8'(8'h50 + k) || fired_last[k] !== (k == 4)) begin
                err_cnt++; $display("FAIL st_byte%0d: got %h/%b want %h/%b", k, fired_data[k], fired_last[k], 8'(8'h50 + k), (k == 4));
            end
        end
    endtask

    task automatic test_truncate();
        int ntr;
        begin_test(1'b1);
        load(0, 8'h70, 7);
        for (int c = 0; c < 9; c++) tick();
        ntr = 0;
        for (int c = 0; c < 9; c++) if (obs_trunc[c]) ntr++;
        vec_cnt++; if (obs_last[3] !== 1'b0 || obs_data[4] !== 8'h73 || obs_last[4] !== 1'b1) begin err_cnt++; $display("FAIL tr_forced_last: got %b/%h/%b want 0/73/1", obs_last[3], obs_data[4], obs_last[4]); end
        vec_cnt++; if (obs_valid[5] !== 1'b0 || obs_rdy[5] !== 4'b0001) begin err_cnt++; $display("FAIL tr_drain: got %b/%b want 0/0001", obs_valid[5], obs_rdy[5]); end
        vec_cnt++; if (obs_trunc[5] !== 1'b1 || obs_drop[5] !== 16'd1) begin err_cnt++; $display("FAIL tr_pulse: got %b/%0d want 1/1", obs_trunc[5], obs_drop[5]); end
        vec_cnt++; if (ntr !== 1) begin err_cnt++; $display("FAIL tr_pulse_count: got %0d want 1", ntr); end
        vec_cnt++; if (nfired !== 4 || rd[0] !== 7) begin err_cnt++; $display("FAIL tr_counts: got fwd %0d popped %0d want 4/7", nfired, rd[0]); end
        vec_cnt++; if (obs_rdy[8] !== 4'b0000 || obs_drop[8] !== 16'd1) begin err_cnt++; $display("FAIL tr_idle: got %b/%0d want 0000/1", obs_rdy[8], obs_drop[8]); end
    endtask

    task automatic test_exact_len();
        int ntr;
        begin_test(1'b1);
        load(0, 8'h80, 4);
        load(1, 8'h90, 1);
        for (int c = 0; c < 9; c++) tick();
        ntr = 0;
        for (int c = 0; c < 9; c++) if (obs_trunc[c]) ntr++;
        vec_cnt++; if (obs_data[4] !== 8'h83 || obs_last[4] !== 1'b1) begin err_cnt++; $display("FAIL ex_last: got %h/%b want 83/1", obs_data[4], obs_last[4]); end
        vec_cnt++; if (ntr !== 0 || obs_drop[8] !== 16'd0) begin err_cnt++; $display("FAIL ex_no_trunc: got pulses %0d drop %0d want 0/0", ntr, obs_drop[8]); end
        vec_cnt++; if (obs_data[6] !== 8'h90 || obs_src[6] !== 2'd1 || obs_last[6] !== 1'b1) begin err_cnt++; $display("FAIL ex_next_pkt: got %h/%0d/%b want 90/1/1", obs_data[6], obs_src[6], obs_last[6]); end
    endtask

    task automatic test_mid_reset();
        begin_test(1'b0);
        en = 4'b0100;
        load(2, 8'h90, 6);
        load(0, 8'hA0, 1);
        tick(); tick(); tick();
        drive();
        #2;
        vec_cnt++; if (ifa.buf_valid !== 1'b1 || ifa.buf_data !== 8'h92 || ifa.hdr_src_port !== 2'd2) begin err_cnt++; $display("FAIL mr_pre: got %b/%h/%0d want 1/92/2", ifa.buf_valid, ifa.buf_data, ifa.hdr_src_port); end
        rst = 1'b1;
        #1;
        vec_cnt++; if (ifa.buf_valid !== 1'b0 || ifa.buf_last !== 1'b0 || ifa.in_ready !== 4'b0000) begin err_cnt++; $display("FAIL mr_async: got %b/%b/%b want 0/0/0000", ifa.buf_valid, ifa.buf_last, ifa.in_ready); end
        vec_cnt++; if (ifa.hdr_src_port !== 2'd0) begin err_cnt++; $display("FAIL mr_src: got %0d want 0", ifa.hdr_src_port); end
        en = 4'b0101;
        drive();
        @(posedge clk);
        #1;
        rst  = 1'b0;
        ncyc = 0;
        for (int c = 0; c < 4; c++) tick();
        vec_cnt++; if (obs_valid[0] !== 1'b0 || obs_data[1] !== 8'hA0 || obs_src[1] !== 2'd0 || obs_rdy[1] !== 4'b0001) begin err_cnt++; $display("FAIL mr_port0_wins: got %b/%h/%0d/%b want 0/a0/0/0001", obs_valid[0], obs_data[1], obs_src[1], obs_rdy[1]); end
        vec_cnt++; if (obs_data[3] !== 8'h92 || obs_src[3] !== 2'd2) begin err_cnt++; $display("FAIL mr_port2_resume: got %h/%0d want 92/2", obs_data[3], obs_src[3]); end
    endtask

    initial begin
        vec_cnt   = 0;
        err_cnt   = 0;
        use_b     = 1'b0;
        en        = 4'hF;
        rdy_pat   = '1;
        ncyc      = 0;
        nfired    = 0;
        drv_ready = 1'b1;
        drv_valid = 4'b0000;
        drv_last  = 4'b0000;
        drv_data  = 32'h0;
        rst       = 1'b1;
        for (int p = 0; p < 4; p++) begin
            len[p] = 0;
            rd[p]  = 0;
        end
        test_reset();
        test_two_ports();
        test_round_robin();
        test_stall();
        test_truncate();
        test_exact_len();
        test_mid_reset();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
`default_nettype wire
